// File: rtl/nn_result_display.sv
// Result-display controller for the MNIST demo: latches the predicted class and a
// short history, converts the confidence score to BCD and drives seven-segment digits.
module nn_result_display #(
  parameter int NUM_DIGITS = 6,
  parameter int CLASS_W    = 4,
  parameter int SCORE_W    = 16,
  parameter int HISTORY    = 2,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    done,
  input  logic [CLASS_W-1:0]      argmax,
  input  logic [SCORE_W-1:0]      score,
  input  logic                    clear,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy,
  output logic                    valid,
  output logic [1:0]              state
);

  localparam int SD    = NUM_DIGITS - 1 - HISTORY;
  localparam int HN    = (HISTORY > 0) ? HISTORY : 1;
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int BIT_W = $clog2(SCORE_W + 1);
  localparam int BCD_W = (SD > 0) ? 4 * SD : 4;

  localparam logic [CLASS_W-1:0] BLANK_CODE = '1;
  localparam logic [6:0]         SEG_BLANK  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  generate
    if (SD < 1) begin : g_sd_check
      $error("nn_result_display: NUM_DIGITS-1-HISTORY must be at least 1");
    end
  endgenerate

  // Largest score representable on SD decimal digits, clipped to the score width.
  function automatic logic [SCORE_W-1:0] sat_limit(input int digits);
    longint p;
    longint lim;
    p   = 1;
    lim = longint'(1) << SCORE_W;
    for (int i = 0; i < digits; i++) begin
      if (p <= lim) p = p * 10;
    end
    if (p - 1 >= lim) return '1;
    return SCORE_W'(p - 1);
  endfunction

  localparam logic [SCORE_W-1:0] SAT_MAX = sat_limit(SD);

  function automatic logic [6:0] glyph(input logic [31:0] v);
    logic [6:0] s;
    case (v)
      32'd0:   s = 7'h3F;
      32'd1:   s = 7'h06;
      32'd2:   s = 7'h5B;
      32'd3:   s = 7'h4F;
      32'd4:   s = 7'h66;
      32'd5:   s = 7'h6D;
      32'd6:   s = 7'h7D;
      32'd7:   s = 7'h07;
      32'd8:   s = 7'h7F;
      32'd9:   s = 7'h6F;
      32'd10:  s = 7'h40;
      default: s = 7'h00;
    endcase
    return (ACTIVE_LOW != 0) ? ~s : s;
  endfunction

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_CONVERT = 2'd2,
    S_SHOW    = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      start_prev_q;
  logic [CNT_W-1:0]          blink_q, blink_d;
  logic                      phase_q, phase_d;
  logic [CLASS_W-1:0]        cur_q, cur_d;
  logic [CLASS_W-1:0]        hist_q [HN];
  logic [CLASS_W-1:0]        hist_d [HN];
  logic [SCORE_W-1:0]        bin_q, bin_d;
  logic [BCD_W-1:0]          bcd_q, bcd_d;
  logic [BIT_W-1:0]          bitcnt_q, bitcnt_d;
  logic [7*NUM_DIGITS-1:0]   hex_q, hex_d;
  logic                      busy_q, valid_q;
  logic                      rise;
  logic                      lead;
  logic [3:0]                nib;
  logic [BCD_W+SCORE_W-1:0]  dd;

  always_comb begin
    state_d  = state_q;
    blink_d  = blink_q;
    phase_d  = phase_q;
    cur_d    = cur_q;
    hist_d   = hist_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    bitcnt_d = bitcnt_q;
    hex_d    = hex_q;
    lead     = 1'b1;
    nib      = '0;
    dd       = '0;
    rise     = start & ~start_prev_q;

    if (state_q == S_BUSY || state_q == S_CONVERT) begin
      if (blink_q == CNT_W'(BLINK_DIV - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_SHOW: begin
        if (rise) begin
          state_d = S_BUSY;
          blink_d = '0;
          phase_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (done) begin
          state_d = S_CONVERT;
          cur_d   = argmax;
          for (int k = HN - 1; k > 0; k--) hist_d[k] = hist_q[k-1];
          hist_d[0] = cur_q;
          bin_d     = (score > SAT_MAX) ? SAT_MAX : score;
          bcd_d     = '0;
          bitcnt_d  = '0;
        end
      end
      default: begin
        // One double-dabble step per cycle; the extra cycle after the last shift hands off to SHOW.
        if (bitcnt_q != BIT_W'(SCORE_W)) begin
          dd       = {add3(bcd_q), bin_q} << 1;
          bcd_d    = dd[BCD_W+SCORE_W-1:SCORE_W];
          bin_d    = dd[SCORE_W-1:0];
          bitcnt_d = bitcnt_q + 1'b1;
        end else begin
          state_d = S_SHOW;
        end
      end
    endcase

    if (clear) begin
      for (int k = 0; k < HN; k++) hist_d[k] = BLANK_CODE;
    end

    if (state_d == S_BUSY || state_d == S_CONVERT) begin
      hex_d[6:0] = phase_d ? glyph(32'd10) : SEG_BLANK;
    end else if (state_d == S_SHOW) begin
      hex_d[6:0] = glyph(32'(cur_d));
    end

    for (int k = 0; k < HISTORY; k++) begin
      hex_d[7*(k+1) +: 7] = glyph(32'(hist_d[k]));
    end

    // Score digits refresh once, when the conversion result is published.
    if (state_q == S_CONVERT && state_d == S_SHOW) begin
      for (int j = SD - 1; j >= 0; j--) begin
        nib = bcd_q[4*j +: 4];
        if (lead && nib == 4'd0 && j != 0) begin
          hex_d[7*(HISTORY+1+j) +: 7] = SEG_BLANK;
        end else begin
          lead = 1'b0;
          hex_d[7*(HISTORY+1+j) +: 7] = glyph(32'(nib));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      blink_q      <= '0;
      phase_q      <= 1'b1;
      cur_q        <= BLANK_CODE;
      for (int k = 0; k < HN; k++) hist_q[k] <= BLANK_CODE;
      hex_q        <= {NUM_DIGITS{SEG_BLANK}};
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      cur_q        <= cur_d;
      hist_q       <= hist_d;
      hex_q        <= hex_d;
      busy_q       <= (state_d == S_BUSY);
      valid_q      <= (state_d == S_SHOW);
    end
  end

  always_ff @(posedge clk) begin
    bin_q    <= bin_d;
    bcd_q    <= bcd_d;
    bitcnt_q <= bitcnt_d;
  end

  assign hex_out = hex_q;
  assign busy    = busy_q;
  assign valid   = valid_q;
  assign state   = state_q;

endmodule
